adc_frame_scheduler: RTL and testbench
======================================

Name: adc_frame_scheduler

Overview:
Sequences one sampling frame across the ADC_CHIP_NO parallel ADCs for the beamforming front end. Each frame runs: conversion start, busy wait, then a one-cycle enable pulse to the parallel-to-serial serializer, then a wait for that transfer to finish. A programmable sample-period timer paces the frames. The block also keeps frame and overrun status for the DSP.

Parameters:
ADC_CHIP_NO, 4, number of ADC chips; sets the busy input width.
CONVST_W, 3, convst_bar low width in clkin cycles; minimum 1.
XFER_CYCLES, 116, serializer occupancy per frame in cycles (20 + 12*ADC_CHIP_NO*2).
PERIOD_W, 16, width of the period and frame counters.
MIN_PERIOD, 128, floor applied to a programmed period.
TIMEOUT_CYC, 255, busy-wait limit in cycles (used only with the optional feature).

Ports:
clkin  in  1  24 MHz system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  level; high means periodic frames are enabled.
period  in  PERIOD_W  frame period in clkin cycles; latched at each tick.
busy  in  ADC_CHIP_NO  ADC BUSY lines, active high, already synchronised.
clr_ovr  in  1  pulse; clears overrun.
convst_bar  out  1  conversion start to all ADCs, active low.
xfer_en  out  1  one-cycle enable pulse to the serializer.
frame_done  out  1  one-cycle pulse when a frame completes.
active  out  1  high whenever state is not IDLE.
overrun  out  1  sticky flag: a tick arrived while a frame was in progress.
frame_cnt  out  PERIOD_W  count of completed frames; wraps.

Behaviour:
- Reset (async, rst_n=0), immediate even mid-frame:
  - outputs: convst_bar=1, xfer_en=0, frame_done=0, active=0, overrun=0, frame_cnt=0.
  - internals: state=IDLE, period counter=0.
- Period timer:
  - While run=0, the counter is held at 0 and no ticks are generated.
  - The first cycle run is sampled high produces a tick.
  - After a tick, the counter loads eff_period-1 and decrements; the next tick fires when it reaches 0.
  - eff_period = max(period, MIN_PERIOD), sampled in the tick cycle.
  - period=0 is therefore treated as MIN_PERIOD.
- State machine:
  - IDLE: on tick, go to CONV.
  - CONV: convst_bar=0 for exactly CONVST_W cycles, then go to WAIT.
  - WAIT: stay at least 1 cycle (covers the ADC busy-assert delay). Leave in the first cycle with busy==0 after that; the following cycle is XFER.
  - XFER: xfer_en=1 in the first XFER cycle only. The state lasts XFER_CYCLES cycles in total, then goes to IDLE.
  - On XFER exit, in the same cycle: frame_done=1 for one cycle and frame_cnt increments, modulo 2^PERIOD_W.
- Latency: tick to convst_bar falling = 1 cycle. convst_bar rising to xfer_en ≥ 2 cycles.
- Overrun: a tick while state≠IDLE sets overrun and the tick is dropped; the frame in flight is unaffected.
- Overrun clear:
  - clr_ovr clears overrun.
  - If clr_ovr and a new overrun occur in the same cycle, set wins.
- run deasserted mid-frame: the current frame completes normally, then the block stays in IDLE. The period counter is forced to 0 at once.
- run reasserted while a frame is still in progress: the immediate tick counts as an overrun.
- active is registered and mirrors state≠IDLE.

Optional Feature:
Macro ADC_BUSY_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter is added. If busy is not all low within TIMEOUT_CYC cycles, the state machine goes to IDLE without asserting xfer_en.
  - The block raises an extra output port busy_to, sticky and cleared by clr_ovr.
  - frame_cnt does not increment on a timeout.
- Undefined: WAIT is unbounded; there is no busy_to port and no timeout counter.

Decomposition:
- Shared package adc_fe_pkg holds:
  - the state encoding IDLE/CONV/WAIT/XFER (2 bits);
  - ADC_CHIP_NO and XFER_CYCLES, so the serializer and the scheduler agree.
- One natural sub-module: adc_period_timer (run, period, MIN_PERIOD floor → tick). The state machine, counters and flags stay in the top.

Test Plan:
1. Reset/basic frame. Reset, then run=1, period=300, busy held high 10 cycles after convst_bar rises.
   - convst_bar low cycles 1–3;
   - xfer_en pulse 11 cycles after convst_bar rises (10 busy + 1);
   - frame_done 116 cycles after xfer_en;
   - frame_cnt=1; next convst_bar falls 300 cycles after the first.
2. Period floor. period=0 and period=50 → ticks every 128 cycles; overrun stays 0 (frame length ≈ 3+1+116 < 128).
3. Overrun. MIN_PERIOD overridden to 16, period=16, busy low → tick during XFER sets overrun=1 and no extra convst_bar. Pulse clr_ovr → overrun=0; if a tick and clr_ovr land in the same cycle, overrun stays 1.
4. run drop. Drop run during XFER → frame completes (frame_done seen, frame_cnt+1), then active=0 and no further convst_bar.
5. Async reset mid-WAIT. Assert rst_n=0 with busy high → all outputs return to reset values within the same cycle; no xfer_en after release until a new tick.
6. ADC_BUSY_TIMEOUT_EN defined, TIMEOUT_CYC=20, busy stuck high → busy_to=1 after 20 WAIT cycles, state IDLE, no xfer_en, frame_cnt unchanged; the next tick starts a normal frame.

Source files
------------

// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared frame-state encoding and ADC front-end geometry for scheduler and serializer
package adc_fe_pkg;
  typedef enum logic [1:0] {IDLE, CONV, WAIT, XFER} state_e;
  localparam int ADC_CHIP_NO = 4;
  localparam int XFER_CYCLES = 20 + 12 * ADC_CHIP_NO * 2;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/adc_period_timer.sv
// adc_period_timer: frame pacing tick with a floor on the programmed period; held idle while run is low
module adc_period_timer #(
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 128
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, eff_period;
  assign eff_period = period < PERIOD_W'(MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : period;
  assign tick = run && cnt_q == '0;
  assign cnt_d = !run ? '0 : tick ? eff_period - PERIOD_W'(1) : cnt_q - PERIOD_W'(1);
  // countdown register; zero while stopped so the first run cycle ticks
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: sequences convst, busy wait, serializer enable and transfer per frame; ADC_BUSY_TIMEOUT_EN adds a busy-wait timeout and busy_to
module adc_frame_scheduler #(
  parameter int ADC_CHIP_NO = adc_fe_pkg::ADC_CHIP_NO,
  parameter int CONVST_W    = 3,
  parameter int XFER_CYCLES = adc_fe_pkg::XFER_CYCLES,
  parameter int PERIOD_W    = 16,
  parameter int MIN_PERIOD  = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [ADC_CHIP_NO-1:0] busy,
  input  logic                   clr_ovr,
  output logic                   convst_bar,
  output logic                   xfer_en,
  output logic                   frame_done,
  output logic                   active,
  output logic                   overrun,
`ifdef ADC_BUSY_TIMEOUT_EN
  output logic                   busy_to,
`endif
  output logic [PERIOD_W-1:0]    frame_cnt
);
  import adc_fe_pkg::*;
  localparam int CNT_W = $clog2(max_int(max_int(CONVST_W, XFER_CYCLES), TIMEOUT_CYC) + 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] frame_cnt_q;
  logic tick, busy_any, xfer_done, to_hit, overrun_d;
  logic convst_bar_q, xfer_en_q, frame_done_q, active_q, overrun_q;
  adc_period_timer #(.PERIOD_W(PERIOD_W), .MIN_PERIOD(MIN_PERIOD)) u_timer (
    .clkin(clkin),
    .rst_n(rst_n),
    .run(run),
    .period(period),
    .tick(tick)
  );
  assign busy_any = |busy;
  assign xfer_done = state_q == XFER && cnt_q == '0;
  assign overrun_d = (tick && state_q != IDLE) || (overrun_q && !clr_ovr);
`ifdef ADC_BUSY_TIMEOUT_EN
  assign to_hit = state_q == WAIT && busy_any && cnt_q >= CNT_W'(TIMEOUT_CYC - 1);
`else
  assign to_hit = 1'b0;
`endif
  // frame sequencing; cnt_q is the per-state phase counter (WAIT counts up from 0, so 0 marks the mandatory first cycle)
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = CONV;
        cnt_d = CNT_W'(CONVST_W - 1);
      end
      CONV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d = '0;
        end
      end
      WAIT: begin
`ifdef ADC_BUSY_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`else
        cnt_d = CNT_W'(1);
`endif
        if (cnt_q != '0 && !busy_any) begin
          state_d = XFER;
          cnt_d = CNT_W'(XFER_CYCLES - 1);
        end else if (to_hit) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
    endcase
  end
  // state, counters and registered outputs derived from the next state so they line up with it
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      convst_bar_q <= 1'b1;
      xfer_en_q <= 1'b0;
      frame_done_q <= 1'b0;
      active_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      convst_bar_q <= state_d != CONV;
      xfer_en_q <= state_d == XFER && state_q != XFER;
      frame_done_q <= xfer_done;
      active_q <= state_d != IDLE;
      overrun_q <= overrun_d;
      frame_cnt_q <= xfer_done ? frame_cnt_q + PERIOD_W'(1) : frame_cnt_q;
    end
`ifdef ADC_BUSY_TIMEOUT_EN
  logic busy_to_q;
  // sticky timeout flag; a new timeout wins over a simultaneous clear
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) busy_to_q <= 1'b0;
    else busy_to_q <= to_hit || (busy_to_q && !clr_ovr);
  assign busy_to = busy_to_q;
`endif
  assign convst_bar = convst_bar_q;
  assign xfer_en = xfer_en_q;
  assign frame_done = frame_done_q;
  assign active = active_q;
  assign overrun = overrun_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler: directed self-checking bench for adc_frame_scheduler
module tb_adc_frame_scheduler;
  localparam int NCH = adc_fe_pkg::ADC_CHIP_NO;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, clr_ovr = 1'b0;
  logic [15:0] period = '0;
  logic [NCH-1:0] busy = '0;
  logic a_convst_bar, a_xfer_en, a_frame_done, a_active, a_overrun, a_busy_to;
  logic b_convst_bar, b_xfer_en, b_frame_done, b_active, b_overrun;
  logic [15:0] a_frame_cnt, b_frame_cnt;
  int cyc = 0, a_low_n = 0, a_xfer_n = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!a_convst_bar) a_low_n <= a_low_n + 1;
    if (a_xfer_en) a_xfer_n <= a_xfer_n + 1;
  end
  adc_frame_scheduler #(.TIMEOUT_CYC(20)) dut (
    .clkin(clk), .rst_n(rst_n), .run(run), .period(period), .busy(busy), .clr_ovr(clr_ovr),
    .convst_bar(a_convst_bar), .xfer_en(a_xfer_en), .frame_done(a_frame_done), .active(a_active),
    .overrun(a_overrun),
`ifdef ADC_BUSY_TIMEOUT_EN
    .busy_to(a_busy_to),
`endif
    .frame_cnt(a_frame_cnt)
  );
`ifdef ADC_BUSY_TIMEOUT_EN
  logic b_busy_to;
`else
  assign a_busy_to = 1'b0;
`endif
  adc_frame_scheduler #(.MIN_PERIOD(16)) dut16 (
    .clkin(clk), .rst_n(rst_n), .run(run), .period(period), .busy(busy), .clr_ovr(clr_ovr),
    .convst_bar(b_convst_bar), .xfer_en(b_xfer_en), .frame_done(b_frame_done), .active(b_active),
    .overrun(b_overrun),
`ifdef ADC_BUSY_TIMEOUT_EN
    .busy_to(b_busy_to),
`endif
    .frame_cnt(b_frame_cnt)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    run = 1'b0;
    busy = '0;
    clr_ovr = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask
  task automatic wait_fall(input int bound, output int t);
    int n = 0;
    t = -1;
    while (a_convst_bar == 1'b0 && n < bound) begin step(1); n++; end
    while (n < bound && t < 0) begin
      step(1);
      n++;
      if (a_convst_bar == 1'b0) t = cyc;
    end
  endtask
  task automatic wait_pulse(input int which, input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound && t < 0; i++) begin
      step(1);
      if ((which == 0 && a_xfer_en) || (which == 1 && a_frame_done) ||
          (which == 2 && b_frame_done) || (which == 3 && a_busy_to)) t = cyc;
    end
  endtask
  task automatic test_reset;
    run = 1'b0;
    rst_n = 1'b0;
    step(3);
    checks++; if (a_convst_bar !== 1'b1) begin errors++; $display("FAIL reset_convst_bar: got %b want 1", a_convst_bar); end
    checks++; if (a_xfer_en !== 1'b0) begin errors++; $display("FAIL reset_xfer_en: got %b want 0", a_xfer_en); end
    checks++; if (a_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", a_frame_done); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", a_active); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", a_overrun); end
    checks++; if (a_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", a_frame_cnt); end
    rst_n = 1'b1;
    step(1);
  endtask
  task automatic test_basic_frame;
    int f1, f2, rise, tx, td, lowcnt;
    period = 16'd300;
    busy = '0;
    run = 1'b1;
    wait_fall(5, f1);
    checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %b want 1", a_active); end
    lowcnt = (f1 >= 0) ? 1 : 0;
    while (a_convst_bar == 1'b0 && lowcnt < 10) begin
      step(1);
      if (a_convst_bar == 1'b0) lowcnt++;
    end
    checks++; if (lowcnt !== 3) begin errors++; $display("FAIL basic_convst_width: got %0d want 3", lowcnt); end
    rise = cyc;
    busy = '1;
    step(10);
    busy = '0;
    wait_pulse(0, 50, tx);
    checks++; if (tx - rise !== 11) begin errors++; $display("FAIL basic_xfer_latency: got %0d want 11", tx - rise); end
    step(1);
    checks++; if (a_xfer_en !== 1'b0) begin errors++; $display("FAIL basic_xfer_one_cycle: got %b want 0", a_xfer_en); end
    tx = tx;
    wait_pulse(1, 200, td);
    checks++; if (td - tx !== 116) begin errors++; $display("FAIL basic_done_latency: got %0d want 116", td - tx); end
    checks++; if (a_frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", a_frame_cnt); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL basic_idle_active: got %b want 0", a_active); end
    wait_fall(400, f2);
    checks++; if (f2 - f1 !== 300) begin errors++; $display("FAIL basic_period: got %0d want 300", f2 - f1); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", a_overrun); end
  endtask
  task automatic test_period_floor;
    int f1, f2, f3, f4;
    run = 1'b0;
    step(150);
    period = 16'd0;
    run = 1'b1;
    wait_fall(5, f1);
    wait_fall(200, f2);
    checks++; if (f2 - f1 !== 128) begin errors++; $display("FAIL floor_p0_a: got %0d want 128", f2 - f1); end
    period = 16'd50;
    wait_fall(200, f3);
    checks++; if (f3 - f2 !== 128) begin errors++; $display("FAIL floor_p0_b: got %0d want 128", f3 - f2); end
    wait_fall(200, f4);
    checks++; if (f4 - f3 !== 128) begin errors++; $display("FAIL floor_p50: got %0d want 128", f4 - f3); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL floor_overrun: got %b want 0", a_overrun); end
  endtask
  task automatic test_overrun;
    int p, td;
    do_reset();
    period = 16'd16;
    busy = '0;
    run = 1'b1;
    p = cyc;
    step(16);
    checks++; if (b_overrun !== 1'b0) begin errors++; $display("FAIL ovr_before_tick: got %b want 0", b_overrun); end
    step(1);
    checks++; if (b_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", b_overrun); end
    checks++; if (b_convst_bar !== 1'b1) begin errors++; $display("FAIL ovr_no_convst_a: got %b want 1", b_convst_bar); end
    step(1);
    checks++; if (b_convst_bar !== 1'b1) begin errors++; $display("FAIL ovr_no_convst_b: got %b want 1", b_convst_bar); end
    run = 1'b0;
    step(2);
    clr_ovr = 1'b1;
    step(1);
    checks++; if (b_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", b_overrun); end
    run = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    checks++; if (b_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", b_overrun); end
    wait_pulse(2, 200, td);
    checks++; if (td - p !== 122) begin errors++; $display("FAIL ovr_frame_done_time: got %0d want 122", td - p); end
    checks++; if (b_frame_cnt !== 16'd1) begin errors++; $display("FAIL ovr_frame_cnt: got %0d want 1", b_frame_cnt); end
  endtask
  task automatic test_run_drop;
    int p, tx, td, low0;
    do_reset();
    period = 16'd300;
    busy = '0;
    run = 1'b1;
    p = cyc;
    wait_pulse(0, 20, tx);
    checks++; if (tx - p !== 6) begin errors++; $display("FAIL drop_xfer_latency: got %0d want 6", tx - p); end
    step(10);
    run = 1'b0;
    wait_pulse(1, 200, td);
    checks++; if (td - tx !== 116) begin errors++; $display("FAIL drop_done_latency: got %0d want 116", td - tx); end
    checks++; if (a_frame_cnt !== 16'd1) begin errors++; $display("FAIL drop_frame_cnt: got %0d want 1", a_frame_cnt); end
    low0 = a_low_n;
    step(400);
    checks++; if (a_low_n - low0 !== 0) begin errors++; $display("FAIL drop_no_convst: got %0d want 0", a_low_n - low0); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL drop_active: got %b want 0", a_active); end
  endtask
  task automatic test_async_reset;
    int q, tx, x0;
    busy = '1;
    run = 1'b1;
    step(6);
    checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL areset_pre_active: got %b want 1", a_active); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL areset_active: got %b want 0", a_active); end
    checks++; if (a_convst_bar !== 1'b1) begin errors++; $display("FAIL areset_convst_bar: got %b want 1", a_convst_bar); end
    checks++; if (a_xfer_en !== 1'b0) begin errors++; $display("FAIL areset_xfer_en: got %b want 0", a_xfer_en); end
    checks++; if (a_frame_cnt !== 16'd0) begin errors++; $display("FAIL areset_frame_cnt: got %0d want 0", a_frame_cnt); end
    run = 1'b0;
    step(2);
    rst_n = 1'b1;
    busy = '0;
    x0 = a_xfer_n;
    step(200);
    checks++; if (a_xfer_n - x0 !== 0) begin errors++; $display("FAIL areset_no_xfer: got %0d want 0", a_xfer_n - x0); end
    run = 1'b1;
    q = cyc;
    wait_pulse(0, 20, tx);
    checks++; if (tx - q !== 6) begin errors++; $display("FAIL areset_new_frame: got %0d want 6", tx - q); end
  endtask
`ifdef ADC_BUSY_TIMEOUT_EN
  task automatic test_busy_timeout;
    int p, f1, rise, tb, tx, x0;
    do_reset();
    period = 16'd300;
    busy = '1;
    x0 = a_xfer_n;
    run = 1'b1;
    p = cyc;
    wait_fall(5, f1);
    while (a_convst_bar == 1'b0 && cyc - p < 10) step(1);
    rise = cyc;
    wait_pulse(3, 60, tb);
    checks++; if (tb - rise !== 20) begin errors++; $display("FAIL to_latency: got %0d want 20", tb - rise); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", a_active); end
    checks++; if (a_frame_cnt !== 16'd0) begin errors++; $display("FAIL to_frame_cnt: got %0d want 0", a_frame_cnt); end
    checks++; if (a_xfer_n - x0 !== 0) begin errors++; $display("FAIL to_no_xfer: got %0d want 0", a_xfer_n - x0); end
    busy = '0;
    wait_pulse(0, 400, tx);
    checks++; if (tx - p !== 306) begin errors++; $display("FAIL to_next_frame: got %0d want 306", tx - p); end
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    checks++; if (a_busy_to !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", a_busy_to); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic_frame();
    test_period_floor();
    test_overrun();
    test_run_drop();
    test_async_reset();
`ifdef ADC_BUSY_TIMEOUT_EN
    test_busy_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
